// File: rtl/mips_md_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Operation codes, sequencer states and small op decode helpers.
package mips_md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } md_state_e;

    function automatic logic op_is_div(md_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(md_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> mult/div sequencer signal bundle.
// master = execute/hazard side, slave = sequencer.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
) ();
    import mips_md_pkg::*;

    logic             StartE;
    md_op_e           MulDivOpE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic             FlushE;
    logic             ReadHiLoE;
    logic             MdStall;
    logic             Busy;
    logic [WIDTH-1:0] HiOut;
    logic [WIDTH-1:0] LoOut;
    logic             DivZero;

    modport master (
        output StartE, MulDivOpE, SrcAE, SrcBE, FlushE, ReadHiLoE,
        input  MdStall, Busy, HiOut, LoOut, DivZero
    );

    modport slave (
        input  StartE, MulDivOpE, SrcAE, SrcBE, FlushE, ReadHiLoE,
        output MdStall, Busy, HiOut, LoOut, DivZero
    );

endinterface

// File: rtl/md_datapath.sv
// Operand/partial registers and one-bit-per-cycle shift-add / restoring divide.
// MULDIV_EARLY_OUT_EN: flag multiplies whose remaining multiplier is exhausted.
module md_datapath
    import mips_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               early_o
);
    localparam int W = WIDTH;

    logic           div_q, div_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [W:0]     rem_w, diff;

    // Divide: acc holds {remainder, dividend/quotient}, mcand low half = divisor
    assign rem_w = acc_q[2*W-1:W-1];
    assign diff  = rem_w - {1'b0, mcand_q[W-1:0]};

    always_comb begin
        div_d    = div_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load_i) begin
            div_d = div_i;
            if (div_i) begin
                acc_d    = {{W{1'b0}}, a_i};
                mcand_d  = {{W{1'b0}}, b_i};
                mplier_d = '0;
            end else begin
                acc_d    = '0;
                mcand_d  = {{W{1'b0}}, a_i};
                mplier_d = b_i;
            end
        end else if (step_i) begin
            if (div_q) begin
                acc_d = {diff[W] ? rem_w[W-1:0] : diff[W-1:0],
                         acc_q[W-2:0], ~diff[W]};
            end else begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            div_q    <= div_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign acc_o = acc_q;

`ifdef MULDIV_EARLY_OUT_EN
    assign early_o = ~div_q & (mplier_q[W-1:1] == '0);
`else
    assign early_o = 1'b0;
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller: FSM, counter, stall, sign fixup, HI/LO.
// Early-out multiply is enabled by MULDIV_EARLY_OUT_EN (see md_datapath).
module muldiv_sequencer
    import mips_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    muldiv_sequencer_if.slave md
);
    localparam int W  = WIDTH;
    localparam int CW = $clog2(WIDTH);

    md_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           div_q, div_d;
    logic           sa_q, sa_d;
    logic           sb_q, sb_d;
    logic           dz_q, dz_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;

    logic           busy, accept, step, early, in_signed;
    logic [W-1:0]   a_abs, b_abs, quo, rem, a_raw;
    logic [2*W-1:0] acc, prod;

    assign busy      = (state_q != S_IDLE);
    assign accept    = (state_q == S_IDLE) & md.StartE & ~md.FlushE;
    assign step      = (state_q == S_RUN);
    assign in_signed = op_is_signed(md.MulDivOpE);

    assign a_abs = (in_signed & md.SrcAE[W-1]) ? -md.SrcAE : md.SrcAE;
    assign b_abs = (in_signed & md.SrcBE[W-1]) ? -md.SrcBE : md.SrcBE;

    md_datapath #(.WIDTH(W)) u_dp (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .step_i  (step),
        .div_i   (op_is_div(md.MulDivOpE)),
        .a_i     (a_abs),
        .b_i     (b_abs),
        .acc_o   (acc),
        .early_o (early)
    );

    // Divide-by-zero keeps |a| in acc; negating it back restores raw SrcAE
    assign prod  = (sa_q ^ sb_q) ? -acc : acc;
    assign quo   = (sa_q ^ sb_q) ? -acc[W-1:0] : acc[W-1:0];
    assign rem   = sa_q ? -acc[2*W-1:W] : acc[2*W-1:W];
    assign a_raw = sa_q ? -acc[W-1:0] : acc[W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    div_d   = op_is_div(md.MulDivOpE);
                    sa_d    = in_signed & md.SrcAE[W-1];
                    sb_d    = in_signed & md.SrcBE[W-1];
                    dz_d    = op_is_div(md.MulDivOpE) & (md.SrcBE == '0);
                    cnt_d   = '0;
                    state_d = dz_d ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1) || early) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (dz_q) begin
                    hi_d = a_raw;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md.Busy    = busy;
    assign md.MdStall = busy & (md.StartE | md.ReadHiLoE);
    assign md.HiOut   = hi_q;
    assign md.LoOut   = lo_q;
    assign md.DivZero = dz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against an arithmetic reference model.
// Honors MULDIV_EARLY_OUT_EN for expected multiply latency.
module tb_muldiv_sequencer;
    import mips_md_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic [31:0] cur_hi, cur_lo;

    muldiv_sequencer_if #(.WIDTH(32)) md ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .md  (md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input md_op_e op, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] hi,
                                  output logic [31:0] lo,
                                  output logic dz, output int lat);
        longint sa, sb, p, q, r;
        logic [63:0] pu;
`ifdef MULDIV_EARLY_OUT_EN
        logic [31:0] m;
        int n;
`endif
        dz  = 1'b0;
        lat = 34;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        hi  = '0;
        lo  = '0;
        case (op)
            MD_MULT: begin
                p = sa * sb;
                {hi, lo} = p;
            end
            MD_MULTU: begin
                pu = {32'b0, a} * {32'b0, b};
                {hi, lo} = pu;
            end
            default: begin
                if (b == 32'd0) begin
                    dz  = 1'b1;
                    hi  = a;
                    lo  = '1;
                    lat = 2;
                end else if (op == MD_DIV) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        if (op == MD_MULT || op == MD_MULTU) begin
            m = (op == MD_MULT && b[31]) ? -b : b;
            n = 0;
            while (m != 0) begin
                n++;
                m = m >> 1;
            end
            lat = ((n == 0) ? 1 : n) + 2;
        end
`endif
    endfunction

    task automatic drive_random();
        md.StartE    = 1'($urandom_range(0, 1));
        md.FlushE    = 1'($urandom_range(0, 1));
        md.ReadHiLoE = 1'($urandom_range(0, 1));
        md.MulDivOpE = md_op_e'($urandom_range(0, 3));
        md.SrcAE     = $urandom;
        md.SrcBE     = $urandom;
    endtask

    task automatic run_op(input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] ehi, elo;
        logic        edz;
        int          lat, k;
        model(op, a, b, ehi, elo, edz, lat);
        md.StartE    = 1'b1;
        md.FlushE    = 1'b0;
        md.MulDivOpE = op;
        md.SrcAE     = a;
        md.SrcBE     = b;
        md.ReadHiLoE = 1'($urandom_range(0, 1));
        #1;
        check("idle_stall", 64'(md.MdStall), 64'd0);
        check("idle_busy", 64'(md.Busy), 64'd0);
        @(negedge clk);
        k = 1;
        while (1) begin
            drive_random();
            #1;
            if (!md.Busy) break;
            check("stall", 64'(md.MdStall), 64'(md.StartE | md.ReadHiLoE));
            check("hold_hi", 64'(md.HiOut), 64'(cur_hi));
            check("hold_lo", 64'(md.LoOut), 64'(cur_lo));
            if (k >= 60) begin
                check("timeout", 64'(k), 64'(lat));
                break;
            end
            @(negedge clk);
            k++;
        end
        md.StartE    = 1'b0;
        md.FlushE    = 1'b0;
        md.ReadHiLoE = 1'b0;
        check("latency", 64'(k), 64'(lat));
        check("hi", 64'(md.HiOut), 64'(ehi));
        check("lo", 64'(md.LoOut), 64'(elo));
        check("divzero", 64'(md.DivZero), 64'(edz));
        cur_hi = ehi;
        cur_lo = elo;
    endtask

    initial begin
        logic [31:0] ra, rb;
        n_tests      = 0;
        n_fail       = 0;
        cur_hi       = '0;
        cur_lo       = '0;
        rst          = 1'b1;
        md.StartE    = 1'b0;
        md.FlushE    = 1'b0;
        md.ReadHiLoE = 1'b0;
        md.MulDivOpE = MD_MULT;
        md.SrcAE     = '0;
        md.SrcBE     = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 64'(md.Busy), 64'd0);
        check("rst_stall", 64'(md.MdStall), 64'd0);
        check("rst_hi", 64'(md.HiOut), 64'd0);
        check("rst_lo", 64'(md.LoOut), 64'd0);
        check("rst_dz", 64'(md.DivZero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        md.ReadHiLoE = 1'b1;
        #1;
        check("read_idle_stall", 64'(md.MdStall), 64'd0);
        md.ReadHiLoE = 1'b0;

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(MD_MULT, -32'sd3, 32'd7);
        run_op(MD_DIV, -32'sd7, 32'd2);
        run_op(MD_DIVU, 32'd100, 32'd0);
        run_op(MD_MULTU, 32'd2, 32'd3);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(MD_DIV, 32'hFFFF_FFF0, 32'd0);
        run_op(MD_MULTU, 32'd5, 32'd1);
        run_op(MD_MULT, 32'd9, 32'd0);

        @(negedge clk);
        md.StartE    = 1'b1;
        md.FlushE    = 1'b1;
        md.MulDivOpE = MD_MULTU;
        md.SrcAE     = 32'd4;
        md.SrcBE     = 32'd4;
        @(negedge clk);
        #1;
        check("flush_busy", 64'(md.Busy), 64'd0);
        md.StartE = 1'b0;
        md.FlushE = 1'b0;

        @(negedge clk);
        md.StartE    = 1'b1;
        md.MulDivOpE = MD_MULTU;
        md.SrcAE     = 32'h1234_5678;
        md.SrcBE     = 32'h8765_4321;
        @(negedge clk);
        md.StartE = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("mid_busy", 64'(md.Busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort_busy", 64'(md.Busy), 64'd0);
        check("abort_hi", 64'(md.HiOut), 64'd0);
        check("abort_lo", 64'(md.LoOut), 64'd0);
        check("abort_dz", 64'(md.DivZero), 64'd0);
        rst    = 1'b0;
        cur_hi = '0;
        cur_lo = '0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(0, 15));
                2:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(md_op_e'($urandom_range(0, 3)), ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide controller beside the execute stage. Accepts MULT/MULTU/DIV/DIVU from the execute stage using the forwarded operands SrcAE/SrcBE, runs a one-bit-per-cycle shift-add or restoring-divide sequence, and writes the architectural HI/LO registers. Drives a stall request to the hazard logic whenever a second mult/div or an mfhi/mflo reaches execute while an operation is still in flight.

## Interface
- WIDTH, 32, operand width; HI/LO are each WIDTH bits
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- StartE  in  1  mult/div instruction valid in execute
- MulDivOpE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- SrcAE  in  WIDTH  forwarded rs operand (multiplicand / dividend)
- SrcBE  in  WIDTH  forwarded rt operand (multiplier / divisor)
- FlushE  in  1  execute-stage instruction is being flushed
- ReadHiLoE  in  1  mfhi/mflo valid in execute
- MdStall  out  1  stall request to hazard unit
- Busy  out  1  state != IDLE
- HiOut  out  WIDTH  HI register (remainder / product high half)
- LoOut  out  WIDTH  LO register (quotient / product low half)
- DivZero  out  1  last accepted op was a divide by zero

## Operation
- States: IDLE, RUN, DONE.
- IDLE: StartE & !FlushE -> latch op, take |SrcAE|, |SrcBE| for signed ops (unsigned otherwise), record result signs, clear counter, -> RUN. DIV/DIVU with SrcBE==0 -> skip RUN, -> DONE with DivZero set.
- RUN: one iteration per cycle; counter 0..WIDTH-1; at count WIDTH-1 -> DONE.
- DONE: apply sign fixup, write HI/LO, -> IDLE.
- Multiply: 2*WIDTH-bit product; MULT negates when signs differ.
- Divide: quotient sign = signA ^ signB, remainder sign = signA. Magnitude math unsigned WIDTH bits, so 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero: HI = SrcAE as latched, LO = all ones, DivZero=1; DivZero cleared on next accepted start.
- MdStall = Busy & (StartE | ReadHiLoE). Accepting in IDLE never stalls. ReadHiLoE in IDLE reads current HI/LO, no stall.
- FlushE only blocks acceptance in IDLE; an op already in RUN/DONE completes (it belongs to an older instruction).
- Operands are consumed only at the accept edge; later SrcAE/SrcBE changes are ignored.

## Timing
- Reset: state IDLE, HiOut=0, LoOut=0, DivZero=0, Busy=0, MdStall=0, counter 0. Reset mid-RUN/DONE aborts with no HI/LO write.
- Start accepted at edge t: RUN for cycles t+1..t+WIDTH, DONE at t+WIDTH+1, new HI/LO visible from t+WIDTH+2 (WIDTH+2 cycles total).
- Divide by zero: DONE at t+1, HI/LO visible from t+2.
- StartE during DONE: stalled one cycle, accepted the following cycle in IDLE.
- Busy and MdStall are combinational from registered state plus inputs. HI/LO change only on the edge leaving DONE.

## Configuration
- MULDIV_EARLY_OUT_EN defined: multiplies leave RUN for DONE as soon as the remaining multiplier shift register is zero, for a minimum of 3 cycles (multiplier 0 or 1). Divide latency is unchanged.
- Undefined: every non-zero-divisor op takes exactly WIDTH+2 cycles.

## Structure
- Shared package mips_md_pkg: MulDivOpE encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and the state enum.
- One sub-module, md_datapath, holds the operand and partial registers plus the per-iteration add/subtract-shift. muldiv_sequencer owns the FSM, counter, stall logic, sign fixup and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> after 34 cycles HI=0xFFFFFFFE, LO=0x00000001; Busy high for 33 cycles.
- MULT -3 * 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 -> HI=100, LO=0xFFFFFFFF, DivZero=1 at cycle t+2. Next MULTU 2*3 clears DivZero.
- Back-to-back: second StartE and ReadHiLoE while Busy -> MdStall=1 each cycle until IDLE. Second op accepted the cycle after DONE and produces correct HI/LO.
- FlushE with StartE in IDLE -> no accept, Busy stays 0. rst asserted at RUN count 10 -> IDLE next cycle, HI/LO = 0.
- With MULDIV_EARLY_OUT_EN: MULTU 5 * 1 -> HI=0, LO=5 visible 3 cycles after accept. Without the macro the same op takes 34 cycles.
